// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS sequence definition and checker state encodings
// Contents: chk_state_t (SEARCH/LOCKED), prbs_next_word() used by both prbs_gen and prbs_chk.
package prbs_pkg;

  // Upper bounds for the generic word builder; instantiations must stay within them.
  localparam int MAX_SIZE   = 128;
  localparam int MAX_LENGTH = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Runs the recurrence `size` steps from a `length`-bit state.
  // state[i] holds s[n-1-i] (bit 0 is the newest bit); taps[i] enables s[n-1-i].
  // The first generated bit lands in word[size-1], the newest in word[0], so
  // word[length-1:0] is the state to continue from.
  function automatic logic [MAX_SIZE-1:0] prbs_next_word(
    input logic [MAX_LENGTH-1:0] state,
    input logic [MAX_LENGTH-1:0] taps,
    input int                    length,
    input int                    size
  );
    logic [MAX_LENGTH-1:0] st;
    logic [MAX_LENGTH-1:0] mask;
    logic [MAX_SIZE-1:0]   word;
    logic                  b;
    st   = state;
    mask = '0;
    word = '0;
    b    = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (i < length) mask[i] = 1'b1;
    end
    for (int k = 0; k < MAX_SIZE; k++) begin
      if (k < size) begin
        b    = ^(st & taps & mask);
        st   = {st[MAX_LENGTH-2:0], b};
        word = {word[MAX_SIZE-2:0], b};
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/prbs_chk_popcount.sv
// rtl/prbs_chk_popcount.sv - registered popcount of an error vector
// Ports: clk, rst_n (async, active low); data/valid in; count/count_valid registered out.
module prbs_popcount #(
  parameter int size  = 32,
  parameter int width = $clog2(size + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [size-1:0]  data,
  input  logic             valid,
  output logic [width-1:0] count,
  output logic             count_valid
);

  logic [width-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < size; i++) begin
      sum = sum + width'(data[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= valid;
      count       <= valid ? sum : '0;
    end
  end

endmodule

// File: rtl/prbs_chk.sv
// rtl/prbs_chk.sv - self-synchronising RX PRBS checker with lock FSM and BER counters
// Ports: gtwiz_userclk_rx_usrclk2_in clock; gtwiz_reset_all_n_in async active-low reset;
//        data_in/data_valid_in received words (bit size-1 oldest); clear_in zeroes counters;
//        locked_out, err_word_out (word had errors), err_cnt_out (bit errors), word_cnt_out.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int               size          = 32,
  parameter int               length        = 7,
  parameter logic [0:length-1] primpoly     = '0,
  parameter int               lock_thresh   = 4,
  parameter int               unlock_thresh = 8,
  parameter int               cnt_width     = 32
) (
  input  logic                 gtwiz_userclk_rx_usrclk2_in,
  input  logic                 gtwiz_reset_all_n_in,
  input  logic [size-1:0]      data_in,
  input  logic                 data_valid_in,
  input  logic                 clear_in,
  output logic                 locked_out,
  output logic                 err_word_out,
  output logic [cnt_width-1:0] err_cnt_out,
  output logic [cnt_width-1:0] word_cnt_out
);

  localparam int CLEAN_W = $clog2(lock_thresh + 1);
  localparam int BAD_W   = $clog2(unlock_thresh + 1);
  localparam int POP_W   = $clog2(size + 1);
  localparam int SUM_W   = ((cnt_width > POP_W) ? cnt_width : POP_W) + 1;

  chk_state_t          state, state_n;
  logic                have_prev, have_prev_n;
  logic [CLEAN_W-1:0]  clean_run, clean_n;
  logic [BAD_W-1:0]    bad_run, bad_n;
  logic [length-1:0]   lfsr, lfsr_n;
  logic                err_word_n;

  logic [MAX_LENGTH-1:0] taps;
  logic [MAX_SIZE-1:0]   pred_full;
  logic [size-1:0]       pred;
  logic [size-1:0]       err_vec;
  logic                  unused_pred;

  logic                  pop_in_valid;
  logic [POP_W-1:0]      pop_count;
  logic                  pop_valid;
  logic [SUM_W-1:0]      err_sum;
  logic [cnt_width-1:0]  err_next;
  logic [cnt_width-1:0]  word_next;

  // Re-pack the ascending tap vector into the package's descending form.
  always_comb begin
    taps = '0;
    for (int i = 0; i < length; i++) begin
      taps[i] = primpoly[i];
    end
  end

  // In SEARCH lfsr holds the seed of the previous valid word; in LOCKED it
  // free-runs, so one prediction path serves both states.
  assign pred_full   = prbs_next_word(MAX_LENGTH'(lfsr), taps, length, size);
  assign pred        = pred_full[size-1:0];
  assign unused_pred = ^pred_full;
  assign err_vec     = data_in ^ pred;

  always_comb begin
    state_n     = state;
    have_prev_n = have_prev;
    clean_n     = clean_run;
    bad_n       = bad_run;
    lfsr_n      = lfsr;
    err_word_n  = 1'b0;
    if (data_valid_in) begin
      case (state)
        SEARCH: begin
          lfsr_n = data_in[length-1:0];
          if (!have_prev) begin
            have_prev_n = 1'b1;
          end else if ((lfsr == '0) || (data_in != pred)) begin
            // an all-zero seed is the stuck LFSR state and never counts as clean
            clean_n = '0;
          end else if (clean_run == CLEAN_W'(lock_thresh - 1)) begin
            state_n = LOCKED;
            clean_n = '0;
            bad_n   = '0;
          end else begin
            clean_n = clean_run + CLEAN_W'(1);
          end
        end
        LOCKED: begin
          // advance from the prediction so received errors never seed the LFSR
          lfsr_n     = pred[length-1:0];
          err_word_n = |err_vec;
          if (|err_vec) begin
            if (bad_run == BAD_W'(unlock_thresh - 1)) begin
              state_n     = SEARCH;
              have_prev_n = 1'b0;
              clean_n     = '0;
              bad_n       = '0;
            end else begin
              bad_n = bad_run + BAD_W'(1);
            end
          end else begin
            bad_n = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge gtwiz_userclk_rx_usrclk2_in or negedge gtwiz_reset_all_n_in) begin
    if (!gtwiz_reset_all_n_in) begin
      state        <= SEARCH;
      have_prev    <= 1'b0;
      clean_run    <= '0;
      bad_run      <= '0;
      lfsr         <= '0;
      err_word_out <= 1'b0;
    end else begin
      state        <= state_n;
      have_prev    <= have_prev_n;
      clean_run    <= clean_n;
      bad_run      <= bad_n;
      lfsr         <= lfsr_n;
      err_word_out <= err_word_n;
    end
  end

  assign locked_out   = (state == LOCKED);
  assign pop_in_valid = data_valid_in && (state == LOCKED);

  // Stage 1: popcount registered alongside err_word_out.
  prbs_popcount #(
    .size  (size),
    .width (POP_W)
  ) u_popcount (
    .clk         (gtwiz_userclk_rx_usrclk2_in),
    .rst_n       (gtwiz_reset_all_n_in),
    .data        (err_vec),
    .valid       (pop_in_valid),
    .count       (pop_count),
    .count_valid (pop_valid)
  );

  // Stage 2: saturating accumulate; the sum is widened so overflow is visible.
  assign err_sum   = SUM_W'(err_cnt_out) + SUM_W'(pop_count);
  assign err_next  = (|err_sum[SUM_W-1:cnt_width]) ? {cnt_width{1'b1}} : err_sum[cnt_width-1:0];
  assign word_next = (&word_cnt_out) ? word_cnt_out : word_cnt_out + cnt_width'(1);

  always_ff @(posedge gtwiz_userclk_rx_usrclk2_in or negedge gtwiz_reset_all_n_in) begin
    if (!gtwiz_reset_all_n_in) begin
      err_cnt_out  <= '0;
      word_cnt_out <= '0;
    end else if (clear_in) begin
      err_cnt_out  <= '0;
      word_cnt_out <= '0;
    end else if (pop_valid) begin
      err_cnt_out  <= err_next;
      word_cnt_out <= word_next;
    end
  end

endmodule

// File: tb/tb_prbs_chk.sv
// tb/tb_prbs_chk.sv - directed self-checking bench for prbs_chk (PRBS7, 32-bit words)
module tb_prbs_chk;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data  = '0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;

  logic        locked, err_word;
  logic [31:0] err_cnt, word_cnt;
  logic        locked4, err_word4;
  logic [3:0]  err_cnt4, word_cnt4;

  int   checks = 0;
  int   errors = 0;
  logic seq_bits [0:8191];
  int   ptr = 0;

  always #5 clk = ~clk;

  prbs_chk #(
    .size(32), .length(7), .primpoly(7'b0000011),
    .lock_thresh(4), .unlock_thresh(8), .cnt_width(32)
  ) dut (
    .gtwiz_userclk_rx_usrclk2_in (clk),
    .gtwiz_reset_all_n_in        (rst_n),
    .data_in                     (data),
    .data_valid_in               (valid),
    .clear_in                    (clear),
    .locked_out                  (locked),
    .err_word_out                (err_word),
    .err_cnt_out                 (err_cnt),
    .word_cnt_out                (word_cnt)
  );

  prbs_chk #(
    .size(32), .length(7), .primpoly(7'b0000011),
    .lock_thresh(4), .unlock_thresh(8), .cnt_width(4)
  ) dut4 (
    .gtwiz_userclk_rx_usrclk2_in (clk),
    .gtwiz_reset_all_n_in        (rst_n),
    .data_in                     (data),
    .data_valid_in               (valid),
    .clear_in                    (clear),
    .locked_out                  (locked4),
    .err_word_out                (err_word4),
    .err_cnt_out                 (err_cnt4),
    .word_cnt_out                (word_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic v, input logic c);
    @(negedge clk);
    data  = d;
    valid = v;
    clear = c;
  endtask

  task automatic next_word(output logic [31:0] w);
    for (int i = 0; i < 32; i++) w[31-i] = seq_bits[ptr+i];
    ptr += 32;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] bad [0:7];
    int          exp_err;

    // x^7 + x^6 + 1 serial sequence: s[n] = s[n-6] ^ s[n-7]
    for (int n = 0; n < 8192; n++) begin
      if (n < 7) seq_bits[n] = 1'b1;
      else       seq_bits[n] = seq_bits[n-6] ^ seq_bits[n-7];
    end
    bad[0] = 32'hDEADBEEF; bad[1] = 32'h12345678; bad[2] = 32'hCAFEF00D; bad[3] = 32'h0F0F0F0F;
    bad[4] = 32'hA5A5A5A5; bad[5] = 32'h13579BDF; bad[6] = 32'hFEEDFACE; bad[7] = 32'h00C0FFEE;

    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err_word", err_word, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);
    rst_n = 1'b1;

    // all-zero words never lock
    for (int i = 0; i < 100; i++) begin
      drive(32'h0, 1'b1, 1'b0);
      chk("zero_unlocked", locked, 0);
    end
    drive(32'h0, 1'b0, 1'b0);
    chk("zero_err_cnt", err_cnt, 0);
    chk("zero_word_cnt", word_cnt, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // acquisition: 1 seed + 4 clean words
    for (int i = 1; i <= 5; i++) begin next_word(w); drive(w, 1'b1, 1'b0); end
    chk("prelock", locked, 0);
    next_word(w); drive(w, 1'b1, 1'b0);          // w6
    chk("lock_after_5", locked, 1);
    chk("lock_err_cnt", err_cnt, 0);
    next_word(w); drive(w, 1'b1, 1'b0);          // w7
    chk("wc_before_first", word_cnt, 0);
    next_word(w); drive(w, 1'b1, 1'b0);          // w8
    chk("wc_first", word_cnt, 1);

    // single flipped bit 3
    next_word(w); drive(w ^ 32'h8, 1'b1, 1'b0);  // w9
    next_word(w); drive(w, 1'b1, 1'b0);          // w10
    chk("bit3_err_word", err_word, 1);
    chk("bit3_cnt_lag", err_cnt, 0);
    next_word(w); drive(w, 1'b1, 1'b0);          // w11
    chk("bit3_err_word_once", err_word, 0);
    chk("bit3_err_cnt", err_cnt, 1);
    next_word(w); drive(w, 1'b1, 1'b0);          // w12
    chk("bit3_locked", locked, 1);
    chk("bit3_word_cnt", word_cnt, 5);

    // fully inverted word
    next_word(w); drive(~w, 1'b1, 1'b0);         // w13
    next_word(w); drive(w, 1'b1, 1'b0);          // w14
    chk("inv_err_word", err_word, 1);
    next_word(w); drive(w, 1'b1, 1'b0);          // w15
    chk("inv_err_word_once", err_word, 0);
    chk("inv_err_cnt", err_cnt, 33);
    chk("inv_err_cnt4_sat", err_cnt4, 15);
    next_word(w); drive(w, 1'b1, 1'b0);          // w16
    chk("inv_locked", locked, 1);

    // 8 foreign words drop lock; prediction keeps following the true sequence
    exp_err = 33;
    for (int i = 0; i < 8; i++) begin
      next_word(w);
      exp_err += $countones(bad[i] ^ w);
      drive(bad[i], 1'b1, 1'b0);
    end
    chk("unlock_not_early", locked, 1);
    next_word(w); drive(w, 1'b1, 1'b0);          // r1 seeds
    chk("unlock_after_8", locked, 0);
    for (int i = 0; i < 4; i++) begin next_word(w); drive(w, 1'b1, 1'b0); end
    chk("relock_not_early", locked, 0);
    next_word(w); drive(w, 1'b1, 1'b0);          // r6
    chk("relock", locked, 1);
    chk("retain_err_cnt", err_cnt, exp_err);
    chk("retain_word_cnt", word_cnt, 19);

    // clear coincides with r6's update
    next_word(w); drive(w, 1'b1, 1'b1);          // r7
    next_word(w); drive(w, 1'b1, 1'b0);          // r8
    chk("clear_err_cnt", err_cnt, 0);
    chk("clear_word_cnt", word_cnt, 0);
    chk("clear_err_cnt4", err_cnt4, 0);

    // 20 single-bit errors, separated by clean words to hold lock
    for (int i = 0; i < 20; i++) begin
      next_word(w); drive(w ^ 32'h1, 1'b1, 1'b0);
      next_word(w); drive(w, 1'b1, 1'b0);
    end
    chk("single_locked", locked, 1);
    next_word(w); drive(w, 1'b1, 1'b0);
    next_word(w); drive(w, 1'b1, 1'b0);
    chk("sat_err_cnt4", err_cnt4, 15);
    chk("err_cnt_20", err_cnt, 20);
    chk("word_cnt_42", word_cnt, 42);
    chk("sat_word_cnt4", word_cnt4, 15);

    // clear beats a simultaneous error update
    next_word(w); drive(w ^ 32'h1, 1'b1, 1'b0);  // A
    next_word(w); drive(w, 1'b1, 1'b1);          // A+1, clear
    next_word(w); drive(w, 1'b1, 1'b0);          // A+2
    chk("clear_wins_err4", err_cnt4, 0);
    chk("clear_wins_err", err_cnt, 0);
    chk("clear_wins_wc", word_cnt, 0);
    next_word(w); drive(w, 1'b1, 1'b0);          // A+3
    chk("after_clear_wc", word_cnt, 1);
    chk("after_clear_err", err_cnt, 0);

    // invalid cycles: no advance, no counting, err_word drops
    next_word(w); drive(w ^ 32'h2, 1'b1, 1'b0);
    drive(32'hFFFFFFFF, 1'b0, 1'b0);
    chk("gap_err_word", err_word, 1);
    drive(32'hFFFFFFFF, 1'b0, 1'b0);
    chk("gap_err_word_clear", err_word, 0);
    chk("gap_err_cnt", err_cnt, 1);
    drive(32'hFFFFFFFF, 1'b0, 1'b0);
    chk("gap_word_cnt", word_cnt, 4);
    next_word(w); drive(w, 1'b1, 1'b0);
    drive(32'h0, 1'b0, 1'b0);
    chk("gap_resume_clean", err_word, 0);

    // asynchronous reset mid-operation
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_err_cnt4", err_cnt4, 0);
    @(negedge clk); rst_n = 1'b1;

    // valid toggling: lock after the same 5 valid words
    for (int i = 0; i < 4; i++) begin
      next_word(w);
      drive(w, 1'b1, 1'b0);
      drive(~w, 1'b0, 1'b0);
    end
    next_word(w); drive(w, 1'b1, 1'b0);
    chk("toggle_prelock", locked, 0);
    drive(32'h0, 1'b0, 1'b0);
    chk("toggle_lock", locked, 1);
    chk("toggle_word_cnt", word_cnt, 0);

    drive(32'h0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_chk.md
Name: prbs_chk

Overview:
- RX-side PRBS checker that consumes the word stream produced by prbs_gen after the serial link or loopback.
- Self-synchronises to the incoming sequence, then free-runs its own LFSR.
- Reports lock status, per-word error flag, saturating bit-error count and checked-word count for BER measurement.
- Sits directly downstream of the transceiver RX datapath, in the RX user clock domain.

Parameters:
- size, 32, word width in bits; must satisfy size >= length.
- length, 7, LFSR length; must match the generator.
- primpoly, 0, [0:length-1] tap vector: serial bit s[n] = XOR over i of primpoly[i] & s[n-1-i]; identical convention to prbs_gen. PRBS7 (x^7+x^6+1) = 7'b0000011.
- lock_thresh, 4, consecutive clean compared words needed to lock.
- unlock_thresh, 8, consecutive errored words needed to drop lock.
- cnt_width, 32, width of both counters.

Ports:
- gtwiz_userclk_rx_usrclk2_in  in  1  RX user clock.
- gtwiz_reset_all_n_in  in  1  asynchronous, active-low reset.
- data_in  in  size  received word; bit size-1 is the oldest bit, same ordering as prbs_gen.
- data_valid_in  in  1  qualifies data_in.
- clear_in  in  1  synchronous clear of both counters.
- locked_out  out  1  checker locked.
- err_word_out  out  1  registered; 1 when the checked word had at least one bit error.
- err_cnt_out  out  cnt_width  saturating bit-error count.
- word_cnt_out  out  cnt_width  saturating count of words checked while locked.

Behaviour:
- Reset: all outputs 0. FSM enters SEARCH. have_prev=0, clean and bad run counters 0, LFSR state 0.
- Words with data_valid_in=0 are ignored entirely: no state advance, no counting. err_word_out is 0 in the following cycle.
- Prediction:
  - next_word(state) runs the recurrence size steps from a length-bit state.
  - The seed state is the newest length bits of a word, data[length-1:0].
- SEARCH state:
  - The first valid word after entry only seeds (have_prev<=1) and is not compared.
  - Each later valid word is compared with next_word(seed of previous valid word).
  - A mismatch, or an all-zero seed (the illegal LFSR state), resets the clean run to 0.
  - A match increments the clean run.
  - When the clean run reaches lock_thresh, go to LOCKED. LFSR state <= seed of the current word. locked_out=1 in the next cycle.
  - err_word_out stays 0 and counters do not change while in SEARCH.
- LOCKED state:
  - The prediction comes only from the internal LFSR, so a received error does not propagate into later predictions.
  - On every valid word: error vector e = data_in XOR predicted; LFSR state <= newest length bits of the predicted word.
  - Pipeline stage 1 (cycle N+1): register e; err_word_out = |e.
  - Pipeline stage 2 (cycle N+2): err_cnt_out += popcount(e) and word_cnt_out += 1, both saturating at all-ones.
  - bad run increments on each errored word and clears on each clean word.
  - When the bad run reaches unlock_thresh: go to SEARCH with have_prev=0 and clean run 0; locked_out=0 in the next cycle. Words already in the pipeline still update the counters.
- clear_in:
  - Zeroes both counters in the next cycle.
  - If clear_in coincides with a stage-2 update, clear wins: result is 0 and the update is discarded.
  - clear_in does not affect the FSM.
- Counters are not cleared when lock is acquired or lost.
- Reset asserted mid-operation: immediate return to reset values, including the pipeline registers.

Decomposition:
- Package prbs_pkg:
  - FSM state encodings (SEARCH=0, LOCKED=1).
  - Function prbs_next_word(state, primpoly, length, size), shared with prbs_gen so both use one sequence definition.
- Sub-module prbs_popcount: registered size-bit popcount producing a result of width clog2(size+1). Used for pipeline stage 2.

Test Plan (size=32, length=7, primpoly=7'b0000011, lock_thresh=4, unlock_thresh=8 unless noted):
1. Reset release, then prbs_gen output with valid held high -> word 1 seeds, words 2-5 clean; locked_out=1 one cycle after word 5; err_cnt_out=0; word_cnt_out increments from the first word checked in LOCKED.
2. Locked, flip bit 3 of one word -> err_word_out=1 for exactly one cycle at N+1; err_cnt_out=1 at N+2; following words clean; locked_out stays 1.
3. Locked, one word fully inverted -> err_cnt_out increases by 32; err_word_out pulses once.
4. data_in=0 with valid high for 100 cycles after reset -> locked_out stays 0; counters stay 0.
5. Locked, 8 random non-PRBS words -> locked_out=0 after the 8th; a clean PRBS stream then relocks after 1 seed + 4 clean words; counters retain their values.
6. cnt_width=4, locked, 20 single-bit errors -> err_cnt_out saturates at 15. clear_in on the same cycle as an error update -> err_cnt_out=0. data_valid_in toggling 1,0,1,0 -> lock after the same 5 valid words.
